// File: rtl/rgb888_to_rgb565_axis.sv
// rgb888_to_rgb565_axis
//   AXI4-Stream pixel converter RGB888 -> RGB565 with round-to-nearest and
//   saturation. It tracks frame position, checks SOF/EOL framing and
//   discards beats received before the first SOF.
//
// Ports
//   i_clk, i_rst          clock, asynchronous active-high reset
//   s_axis_*              24-bit RGB888 input stream (tuser = SOF, tlast = EOL)
//   m_axis_*              16-bit RGB565 output stream, sideband forwarded as-is
//   i_err_clr             clears all sticky flags
//   o_err_eol_early       sticky: tlast before the last column
//   o_err_eol_late        sticky: tlast missing on the last column
//   o_err_sof             sticky: tuser away from pixel (0,0)
//   o_drop                sticky: beats discarded while waiting for SOF
module rgb888_to_rgb565_axis #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned V_ACTIVE = 480
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [23:0] s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  input  logic        s_axis_tuser,
  input  logic        s_axis_tlast,
  output logic [15:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tuser,
  output logic        m_axis_tlast,
  input  logic        i_err_clr,
  output logic        o_err_eol_early,
  output logic        o_err_eol_late,
  output logic        o_err_sof,
  output logic        o_drop
);

  localparam int unsigned XW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int unsigned YW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(V_ACTIVE - 1);

  typedef enum logic {
    WAIT_SOF = 1'b0,
    ACTIVE   = 1'b1
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [XW-1:0]   r_x, w_x_nxt, w_px;
  logic [YW-1:0]   r_y, w_y_nxt, w_py;
  logic            w_set_early, w_set_late, w_set_sof, w_set_drop;

  logic            r_s_ready;
  logic            r_m_valid, r_m_user, r_m_last;
  logic [15:0]     r_m_data;
  logic            r_skid_valid, r_skid_user, r_skid_last;
  logic [15:0]     r_skid_data;
  logic            r_err_early, r_err_late, r_err_sof, r_drop;

  // Per-channel rounding: add half an LSB of the target width at 9 bits,
  // saturate when the sum overflows 8 bits.
  logic [8:0]  w_r_sum, w_g_sum, w_b_sum;
  logic [4:0]  w_r5, w_b5;
  logic [5:0]  w_g6;
  logic [15:0] w_pix;

  assign w_r_sum = 9'(s_axis_tdata[23:16]) + 9'd4;
  assign w_g_sum = 9'(s_axis_tdata[15:8])  + 9'd2;
  assign w_b_sum = 9'(s_axis_tdata[7:0])   + 9'd4;
  assign w_r5    = (w_r_sum > 9'd255) ? 5'd31 : 5'(w_r_sum >> 3);
  assign w_g6    = (w_g_sum > 9'd255) ? 6'd63 : 6'(w_g_sum >> 2);
  assign w_b5    = (w_b_sum > 9'd255) ? 5'd31 : 5'(w_b_sum >> 3);
  assign w_pix   = {w_r5, w_g6, w_b5};

  // Handshake: a beat is forwarded only once framing has locked onto an SOF.
  logic w_accept, w_fwd, w_out_free, w_skid_nxt;

  assign w_accept   = s_axis_tvalid & r_s_ready;
  assign w_fwd      = w_accept & ((r_state == ACTIVE) | s_axis_tuser);
  assign w_out_free = ~r_m_valid | m_axis_tready;
  assign w_skid_nxt = ~w_out_free & (r_skid_valid | w_fwd);

  // Output register plus one-entry skid; skid drains before new input.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_s_ready    <= 1'b0;
      r_m_valid    <= 1'b0;
      r_m_data     <= 16'd0;
      r_m_user     <= 1'b0;
      r_m_last     <= 1'b0;
      r_skid_valid <= 1'b0;
      r_skid_data  <= 16'd0;
      r_skid_user  <= 1'b0;
      r_skid_last  <= 1'b0;
    end else begin
      r_s_ready <= ~w_skid_nxt;
      if (w_out_free) begin
        if (r_skid_valid) begin
          r_m_valid    <= 1'b1;
          r_m_data     <= r_skid_data;
          r_m_user     <= r_skid_user;
          r_m_last     <= r_skid_last;
          r_skid_valid <= 1'b0;
        end else if (w_fwd) begin
          r_m_valid <= 1'b1;
          r_m_data  <= w_pix;
          r_m_user  <= s_axis_tuser;
          r_m_last  <= s_axis_tlast;
        end else begin
          r_m_valid <= 1'b0;
        end
      end else if (w_fwd) begin
        r_skid_valid <= 1'b1;
        r_skid_data  <= w_pix;
        r_skid_user  <= s_axis_tuser;
        r_skid_last  <= s_axis_tlast;
      end
    end
  end

  // Framing state, position counters and sticky flags.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= WAIT_SOF;
      r_x         <= '0;
      r_y         <= '0;
      r_err_early <= 1'b0;
      r_err_late  <= 1'b0;
      r_err_sof   <= 1'b0;
      r_drop      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_x         <= w_x_nxt;
      r_y         <= w_y_nxt;
      r_err_early <= (r_err_early & ~i_err_clr) | w_set_early;
      r_err_late  <= (r_err_late  & ~i_err_clr) | w_set_late;
      r_err_sof   <= (r_err_sof   & ~i_err_clr) | w_set_sof;
      r_drop      <= (r_drop      & ~i_err_clr) | w_set_drop;
    end
  end

  // An SOF beat always counts as pixel (0,0), resyncing the counters.
  assign w_px = s_axis_tuser ? '0 : r_x;
  assign w_py = s_axis_tuser ? '0 : r_y;

  always_comb begin
    w_state_nxt = r_state;
    w_x_nxt     = r_x;
    w_y_nxt     = r_y;
    w_set_early = 1'b0;
    w_set_late  = 1'b0;
    w_set_sof   = 1'b0;
    w_set_drop  = 1'b0;

    if (w_accept) begin
      case (r_state)
        WAIT_SOF: begin
          if (!s_axis_tuser) begin
            w_set_drop = 1'b1;
          end else begin
            w_state_nxt = ACTIVE;
          end
        end
        ACTIVE: begin
          if (s_axis_tuser && ((r_x != '0) || (r_y != '0))) begin
            w_set_sof = 1'b1;
          end
        end
        default: w_state_nxt = WAIT_SOF;
      endcase
    end

    if (w_fwd) begin
      if (s_axis_tlast && (w_px != X_LAST)) begin
        // Early EOL: trust tlast and start the next line.
        w_set_early = 1'b1;
        w_x_nxt     = '0;
        w_y_nxt     = (w_py == Y_LAST) ? '0 : w_py + YW'(1);
      end else if (w_px == X_LAST) begin
        w_set_late  = ~s_axis_tlast;
        w_x_nxt     = '0;
        w_y_nxt     = (w_py == Y_LAST) ? '0 : w_py + YW'(1);
      end else begin
        w_x_nxt     = w_px + XW'(1);
        w_y_nxt     = w_py;
      end
    end
  end

  assign s_axis_tready   = r_s_ready;
  assign m_axis_tvalid   = r_m_valid;
  assign m_axis_tdata    = r_m_data;
  assign m_axis_tuser    = r_m_user;
  assign m_axis_tlast    = r_m_last;
  assign o_err_eol_early = r_err_early;
  assign o_err_eol_late  = r_err_late;
  assign o_err_sof       = r_err_sof;
  assign o_drop          = r_drop;

endmodule
